// File: rtl/data_ram_if.sv
// Request/response bundle between the CPU MEM stage and the data RAM.
// The master drives requests; the slave returns read data and the timer interrupt.
interface data_ram_if;
   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [3:0]  sel_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        int_o;

   modport master (
      output ce_i, we_i, addr_i, sel_i, data_i,
      input  data_o, int_o
   );

   modport slave (
      input  ce_i, we_i, addr_i, sel_i, data_i,
      output data_o, int_o
   );
endinterface

// File: rtl/data_ram.sv
// Word-wide data RAM with combinational reads and byte-lane writes, plus a
// memory-mapped compare/reload timer whose level interrupt feeds CP0.
module data_ram #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter logic [31:0] MMIO_BASE  = 32'h1FFF_FF00
) (
   input logic       clk,
   input logic       rst,
   data_ram_if.slave bus
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [5:0] {
      OFF_COUNT   = 6'h00,
      OFF_COMPARE = 6'h01,
      OFF_CTRL    = 6'h02,
      OFF_STATUS  = 6'h03,
      OFF_LOAD    = 6'h04
   } mmio_off_t;

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [5:0]            word_off;
   logic                  mmio_hit;
   logic                  ram_wr;
   logic                  reg_wr;
   logic                  count_wr;
   logic                  match;
   logic                  pend_clr;

   logic [31:0] count;
   logic [31:0] compare;
   logic [31:0] load;
   logic [2:0]  ctrl;
   logic        pend;
   logic [31:0] rd_data;
   logic        unused_ok;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] r;
      r = old_v;
      for (int unsigned i = 0; i < 4; i++) begin
         if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   assign word_idx  = bus.addr_i[ADDR_WIDTH+1:2];
   assign word_off  = bus.addr_i[7:2];
   assign mmio_hit  = (bus.addr_i[31:8] == MMIO_BASE[31:8]);
   assign ram_wr    = bus.ce_i & bus.we_i & ~mmio_hit;
   assign reg_wr    = bus.ce_i & bus.we_i & mmio_hit;
   assign count_wr  = reg_wr && (word_off == OFF_COUNT);
   // A CPU write to COUNT preempts the match branch entirely.
   assign match     = ctrl[0] && (count == compare) && !count_wr;
   assign pend_clr  = reg_wr && (word_off == OFF_STATUS) && bus.sel_i[0] && bus.data_i[0];
   assign unused_ok = ^bus.addr_i[1:0];

   always_ff @(posedge clk) begin
      if (ram_wr) mem[word_idx] <= lane_merge(mem[word_idx], bus.data_i, bus.sel_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         compare <= '1;
         load    <= '0;
         ctrl    <= '0;
         pend    <= 1'b0;
      end else begin
         if (count_wr)     count <= lane_merge(count, bus.data_i, bus.sel_i);
         else if (match)   count <= ctrl[1] ? load : count + 32'd1;
         else if (ctrl[0]) count <= count + 32'd1;

         if (reg_wr && (word_off == OFF_COMPARE))
            compare <= lane_merge(compare, bus.data_i, bus.sel_i);
         if (reg_wr && (word_off == OFF_LOAD))
            load <= lane_merge(load, bus.data_i, bus.sel_i);
         if (reg_wr && (word_off == OFF_CTRL) && bus.sel_i[0])
            ctrl <= bus.data_i[2:0];

         if (match)         pend <= 1'b1;
         else if (pend_clr) pend <= 1'b0;
      end
   end

   always_comb begin
      rd_data = '0;
      if (!rst && bus.ce_i && !bus.we_i) begin
         if (mmio_hit) begin
            case (word_off)
               OFF_COUNT:   rd_data = count;
               OFF_COMPARE: rd_data = compare;
               OFF_CTRL:    rd_data = {29'b0, ctrl};
               OFF_STATUS:  rd_data = {31'b0, pend};
               OFF_LOAD:    rd_data = load;
               default:     rd_data = '0;
            endcase
         end else begin
            rd_data = mem[word_idx];
         end
      end
   end

   assign bus.data_o = rd_data;
   assign bus.int_o  = pend & ctrl[2];
endmodule

// File: tb/tb_data_ram.sv
// Directed and randomized checks of data_ram against a behavioural model of
// the RAM words and timer registers.
module tb_data_ram;
   localparam int unsigned AW   = 10;
   localparam logic [31:0] BASE = 32'h1FFF_FF00;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_ram_if bus();

   data_ram #(.ADDR_WIDTH(AW), .MMIO_BASE(BASE)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] ref_mem [int unsigned];
   logic [31:0] m_count, m_cmp, m_load;
   logic [2:0]  m_ctrl;
   logic        m_pend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] nw,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++)
         if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   function automatic bit is_mmio(input logic [31:0] a);
      return a[31:8] == BASE[31:8];
   endfunction

   function automatic int unsigned ram_idx(input logic [31:0] a);
      return (a >> 2) % (32'd1 << AW);
   endfunction

   function automatic logic [31:0] mmio_read(input logic [31:0] a);
      case (a[7:0] & 8'hFC)
         8'h00:   return m_count;
         8'h04:   return m_cmp;
         8'h08:   return {29'b0, m_ctrl};
         8'h0C:   return {31'b0, m_pend};
         8'h10:   return m_load;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_count = 32'h0; m_cmp = 32'hFFFF_FFFF; m_load = 32'h0; m_ctrl = 3'b0; m_pend = 1'b0;
   endtask

   task automatic model_step(input logic ce, input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] data);
      logic        wr, cw, hit;
      logic [7:0]  off;
      logic [31:0] n_count;
      logic        n_pend;
      wr  = ce && we;
      hit = is_mmio(addr);
      off = addr[7:0] & 8'hFC;
      cw  = wr && hit && off == 8'h00;
      hit = m_ctrl[0] && (m_count == m_cmp) && !cw;
      n_pend = m_pend;
      if (cw)            n_count = merge(m_count, data, sel);
      else if (hit)      n_count = m_ctrl[1] ? m_load : m_count + 1;
      else if (m_ctrl[0]) n_count = m_count + 1;
      else               n_count = m_count;
      if (hit) n_pend = 1'b1;
      else if (wr && is_mmio(addr) && off == 8'h0C && sel[0] && data[0]) n_pend = 1'b0;
      if (wr && is_mmio(addr)) begin
         if (off == 8'h04) m_cmp  = merge(m_cmp, data, sel);
         if (off == 8'h10) m_load = merge(m_load, data, sel);
         if (off == 8'h08 && sel[0]) m_ctrl = data[2:0];
      end
      if (wr && !is_mmio(addr)) begin
         if (ref_mem.exists(ram_idx(addr)))
            ref_mem[ram_idx(addr)] = merge(ref_mem[ram_idx(addr)], data, sel);
         else if (sel == 4'hF)
            ref_mem[ram_idx(addr)] = data;
      end
      m_count = n_count;
      m_pend  = n_pend;
   endtask

   task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] data);
      bus.ce_i = ce; bus.we_i = we; bus.addr_i = addr; bus.sel_i = sel; bus.data_i = data;
   endtask

   // One bus cycle: check outputs against the model, then advance the model at the edge.
   task automatic cycle(input logic ce, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] data, input string tag);
      drive(ce, we, addr, sel, data);
      #1;
      chk({tag, ":int"}, {31'b0, bus.int_o}, {31'b0, m_pend & m_ctrl[2]});
      if (!ce || we)        chk({tag, ":rd0"}, bus.data_o, 32'h0);
      else if (is_mmio(addr)) chk({tag, ":mmio"}, bus.data_o, mmio_read(addr));
      else if (ref_mem.exists(ram_idx(addr))) chk({tag, ":ram"}, bus.data_o, ref_mem[ram_idx(addr)]);
      @(posedge clk);
      model_step(ce, we, addr, sel, data);
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel,
                     input string tag);
      cycle(1'b1, 1'b1, addr, sel, data, tag);
   endtask

   task automatic rd_expect(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      drive(1'b1, 1'b0, addr, 4'h0, 32'h0);
      #1;
      chk({tag, ":const"}, bus.data_o, exp);
      cycle(1'b1, 1'b0, addr, 4'h0, 32'h0, tag);
   endtask

   initial begin
      logic [31:0] a;
      int          waited;
      rst = 1'b1;
      model_reset();
      drive(1'b1, 1'b0, BASE + 32'h4, 4'h0, 32'h0);
      #2;
      chk("reset_data", bus.data_o, 32'h0);
      chk("reset_int", {31'b0, bus.int_o}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      rd_expect(BASE + 32'h00, 32'h0, "rst_count");
      rd_expect(BASE + 32'h04, 32'hFFFF_FFFF, "rst_compare");
      rd_expect(BASE + 32'h08, 32'h0, "rst_ctrl");
      rd_expect(BASE + 32'h0C, 32'h0, "rst_status");
      rd_expect(BASE + 32'h10, 32'h0, "rst_load");

      wr(32'h10, 32'hAABB_CCDD, 4'hF, "bw_full");
      rd_expect(32'h10, 32'hAABB_CCDD, "bw_rd1");
      wr(32'h10, 32'h00EE_0000, 4'b0100, "bw_lane");
      rd_expect(32'h10, 32'hAAEE_CCDD, "bw_rd2");
      rd_expect(32'h10 + 32'd4 * (32'd1 << AW), 32'hAAEE_CCDD, "bw_alias");

      wr(32'h20, 32'h1234_5678, 4'hF, "gate_init");
      cycle(1'b0, 1'b1, 32'h20, 4'hF, 32'hDEAD_BEEF, "gate_nce");
      rd_expect(32'h20, 32'h1234_5678, "gate_rd");

      wr(BASE + 32'h10, 32'h0, 4'hF, "rl_load");
      wr(BASE + 32'h04, 32'h5, 4'hF, "rl_cmp");
      wr(BASE + 32'h08, 32'h7, 4'hF, "rl_ctrl");
      for (int i = 0; i <= 5; i++) rd_expect(BASE, i, "rl_step");
      chk("rl_int_high", {31'b0, bus.int_o}, 32'h1);
      rd_expect(BASE, 32'h0, "rl_reloaded");
      wr(BASE + 32'h0C, 32'h1, 4'hF, "rl_clear");
      chk("rl_int_low", {31'b0, bus.int_o}, 32'h0);
      waited = 0;
      while (bus.int_o !== 1'b1 && waited < 20) begin
         cycle(1'b1, 1'b0, BASE, 4'h0, 32'h0, "rl_wait");
         waited++;
      end
      chk("rl_reassert", {31'b0, bus.int_o}, 32'h1);

      wr(BASE + 32'h08, 32'h0, 4'hF, "wr_stop");
      wr(BASE + 32'h0C, 32'h1, 4'hF, "wr_clr");
      wr(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, "wr_count");
      wr(BASE + 32'h04, 32'h1, 4'hF, "wr_cmp");
      wr(BASE + 32'h08, 32'h5, 4'hF, "wr_ctrl");
      rd_expect(BASE, 32'hFFFF_FFFF, "wrap_max");
      rd_expect(BASE, 32'h0, "wrap_zero");
      rd_expect(BASE, 32'h1, "wrap_one");
      rd_expect(BASE, 32'h2, "wrap_two");
      chk("wrap_int", {31'b0, bus.int_o}, 32'h1);

      wr(BASE + 32'h08, 32'h0, 4'hF, "pc_stop");
      wr(BASE + 32'h00, 32'h50, 4'hF, "pc_count");
      wr(BASE + 32'h04, 32'h50, 4'hF, "pc_cmp");
      wr(BASE + 32'h08, 32'h1, 4'hF, "pc_en");
      wr(BASE + 32'h00, 32'h100, 4'hF, "pc_collide");
      rd_expect(BASE, 32'h100, "pc_written");

      wr(BASE + 32'h08, 32'h0, 4'hF, "ps_stop");
      wr(BASE + 32'h0C, 32'h1, 4'hF, "ps_clr0");
      wr(BASE + 32'h00, 32'h60, 4'hF, "ps_count");
      wr(BASE + 32'h04, 32'h60, 4'hF, "ps_cmp");
      wr(BASE + 32'h08, 32'h5, 4'hF, "ps_en");
      wr(BASE + 32'h0C, 32'h1, 4'hF, "ps_collide");
      rd_expect(BASE + 32'h0C, 32'h1, "ps_status");
      chk("ps_int", {31'b0, bus.int_o}, 32'h1);

      drive(1'b1, 1'b0, BASE + 32'h04, 4'h0, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_int", {31'b0, bus.int_o}, 32'h0);
      chk("ar_data", bus.data_o, 32'h0);
      model_reset();
      rst = 1'b0;
      @(posedge clk);
      model_step(1'b1, 1'b0, BASE + 32'h04, 4'h0, 32'h0);
      @(negedge clk);
      rd_expect(BASE + 32'h00, 32'h0, "ar_count");
      rd_expect(BASE + 32'h04, 32'hFFFF_FFFF, "ar_compare");
      rd_expect(BASE + 32'h08, 32'h0, "ar_ctrl");
      rd_expect(BASE + 32'h0C, 32'h0, "ar_status");
      rd_expect(BASE + 32'h10, 32'h0, "ar_load");

      wr(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, "um_wr");
      rd_expect(BASE + 32'h40, 32'h0, "um_rd");
      rd_expect(BASE + 32'h00, 32'h0, "um_count");
      rd_expect(BASE + 32'h04, 32'hFFFF_FFFF, "um_compare");
      rd_expect(BASE + 32'h08, 32'h0, "um_ctrl");
      rd_expect(BASE + 32'h10, 32'h0, "um_load");

      for (int i = 0; i < 16; i++) wr(32'h400 + i * 4, $urandom, 4'hF, "rnd_init");
      for (int i = 0; i < 300; i++) begin
         a = ($urandom & 32'h0FF0_0000) | 32'h400 | ($urandom_range(0, 15) << 2)
             | $urandom_range(0, 3);
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
               4'($urandom_range(0, 15)), $urandom, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
